// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM read engine: RAM geometry, FSM states and
// the hex-to-seven-segment table used by the optional display outputs.
package ram_reader_pkg;

  localparam int RAM_AW = 10;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Active-low segments, bit order g..a, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/ram_reader_fifo.sv
// Synchronous FIFO for the read engine output stream; head is shown
// combinationally on dout and forced to zero while empty.
module ram_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);

  // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the empty-gated dout hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/ram_reader.sv
// Streaming read engine: walks a wrapping RAM address range and streams the
// bytes out through a credit-counted FIFO. Define RAM_READER_HEX_EN to add
// the hex_hi/hex_lo seven-segment view of the last accepted byte.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAM_AW-1:0] base,
  input  logic [RAM_AW:0]   len,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_re,
  input  logic [RAM_DW-1:0] ram_q,
  output logic [RAM_DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef RAM_READER_HEX_EN
  output logic [6:0]        hex_hi,
  output logic [6:0]        hex_lo,
`endif
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] addr_q;
  logic [RAM_AW:0]   remaining_q;
  logic              cap_q;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              issue, pop, last_pop;

  // Credits: FIFO entries plus reads in the RAM pipe (ram_re stage, capture stage).
  assign used      = {1'b0, count} + (CW + 1)'(ram_re) + (CW + 1)'(cap_q);
  assign issue     = (state_q == RUN) && (remaining_q != '0) && (used < (CW + 1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign last_pop  = (state_q == DRAIN) && pop && (count == CW'(1)) && !ram_re && !cap_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next-state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (len != '0))                 state_d = RUN;
      RUN:     if (issue && (remaining_q == (RAM_AW+1)'(1))) state_d = DRAIN;
      DRAIN:   if (last_pop)                             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      ram_addr    <= '0;
      ram_re      <= 1'b0;
      cap_q       <= 1'b0;
      done        <= 1'b0;
    end else begin
      ram_re <= issue;
      cap_q  <= ram_re;
      done   <= last_pop || ((state_q == IDLE) && start && (len == '0));
      if ((state_q == IDLE) && start) begin
        addr_q      <= base;
        remaining_q <= len;
      end else if (issue) begin
        ram_addr    <= addr_q;
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  ram_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (RAM_DW),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap_q),
    .din   (ram_q),
    .pop   (pop),
    .dout  (out_data),
    .count (count)
  );

`ifdef RAM_READER_HEX_EN
  logic [RAM_DW-1:0] shown_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   shown_q <= '0;
    else if (pop) shown_q <= out_data;
  end

  assign hex_hi = HEX_SEG[shown_q[7:4]];
  assign hex_lo = HEX_SEG[shown_q[3:0]];
`endif

endmodule
